// File: rtl/stage_sequencer.sv
// Stage sequencer: walks the enabled datapath stages for a configured number of
// rounds, framing each run with a load strobe, a write strobe and a ready pulse.
module stage_sequencer #(
   parameter int unsigned NUM_STAGES = 5,
   parameter int unsigned RND_W      = 5,
   parameter int unsigned TO_W       = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [RND_W-1:0]      rounds_cfg,
   input  logic [NUM_STAGES-1:0] stage_mask,
   input  logic [NUM_STAGES-1:0] stage_ready,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic                  ld_fr,
   output logic                  ld_fw,
   output logic [RND_W-1:0]      round_idx,
   output logic                  busy,
   output logic                  ready,
   output logic                  error
);

   typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StWrite, StDone} state_e;

   localparam logic [NUM_STAGES-1:0] StageOne = NUM_STAGES'(1);
   localparam logic [RND_W-1:0]      RndOne   = RND_W'(1);
   localparam logic [TO_W-1:0]       ToOne    = TO_W'(1);
   // Last WAIT cycle before timeout: counter value 2^TO_W-2 is the 2^TO_W-1'th cycle.
   localparam logic [TO_W-1:0]       ToLast   = ~ToOne;

   state_e                  state_q, state_d;
   logic [NUM_STAGES-1:0]   mask_q, mask_d;
   logic [NUM_STAGES-1:0]   sel_q, sel_d;
   logic [RND_W-1:0]        rounds_q, rounds_d;
   logic [RND_W-1:0]        round_q, round_d;
   logic [TO_W-1:0]         to_q, to_d;
   logic                    err_q, err_d;
   logic [NUM_STAGES-1:0]   lowest_en, above_en, next_en;

   // Stage selection as one-hot: isolate lowest enabled stage, and lowest enabled above sel_q.
   always_comb begin
      lowest_en = mask_q & (~mask_q + StageOne);
      above_en  = mask_q & ~(sel_q | (sel_q - StageOne));
      next_en   = above_en & (~above_en + StageOne);
   end

   // Next-state logic; abort overrides everything, including register updates.
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      sel_d    = sel_q;
      rounds_d = rounds_q;
      round_d  = round_q;
      to_d     = to_q;
      err_d    = err_q;
      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  mask_d   = stage_mask;
                  rounds_d = rounds_cfg;
                  round_d  = '0;
                  err_d    = 1'b0;
                  state_d  = StLoad;
               end
            end
            StLoad: begin
               if ((mask_q == '0) || (rounds_q == '0)) begin
                  state_d = StWrite;
               end else begin
                  sel_d   = lowest_en;
                  state_d = StIssue;
               end
            end
            StIssue: begin
               to_d    = '0;
               state_d = StWait;
            end
            StWait: begin
               if ((stage_ready & sel_q) != '0) begin
                  if (next_en != '0) begin
                     sel_d   = next_en;
                     state_d = StIssue;
                  end else if (round_q == (rounds_q - RndOne)) begin
                     state_d = StWrite;
                  end else begin
                     round_d = round_q + RndOne;
                     sel_d   = lowest_en;
                     state_d = StIssue;
                  end
               end else if (to_q == ToLast) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  to_d = to_q + ToOne;
               end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         mask_q   <= '0;
         sel_q    <= '0;
         rounds_q <= '0;
         round_q  <= '0;
         to_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         sel_q    <= sel_d;
         rounds_q <= rounds_d;
         round_q  <= round_d;
         to_q     <= to_d;
         err_q    <= err_d;
      end
   end

   // Moore outputs decoded from state and registers only.
   always_comb begin
      stage_start = (state_q == StIssue) ? sel_q : '0;
      ld_fr       = (state_q == StLoad);
      ld_fw       = (state_q == StWrite);
      ready       = (state_q == StDone);
      busy        = (state_q != StIdle);
      round_idx   = round_q;
      error       = err_q;
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a run-level procedural model sets per-cycle expectations,
// a negedge process compares them, and a monitor pins directed scenarios to literals.
module tb_stage_sequencer;

   localparam int NS = 5;
   localparam int RW = 5;
   localparam int TW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [RW-1:0] rounds_cfg = '0;
   logic [NS-1:0] stage_mask = '0;
   logic [NS-1:0] stage_ready = '0;
   logic [NS-1:0] stage_start;
   logic          ld_fr, ld_fw, busy, ready, error;
   logic [RW-1:0] round_idx;

   stage_sequencer #(.NUM_STAGES(NS), .RND_W(RW), .TO_W(TW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .rounds_cfg(rounds_cfg),
      .stage_mask(stage_mask), .stage_ready(stage_ready), .stage_start(stage_start),
      .ld_fr(ld_fr), .ld_fw(ld_fw), .round_idx(round_idx), .busy(busy), .ready(ready),
      .error(error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cycle = 0;

   // Per-cycle expectations written by the model
   logic [NS-1:0] exp_ss = '0;
   logic          exp_fr = 0, exp_fw = 0, exp_rdy = 0, exp_busy = 0, exp_err = 0;
   logic [RW-1:0] exp_rnd = '0;
   bit            check_en = 0;

   // Model state
   logic [RW-1:0] m_rnd = '0;
   logic          m_err = 0;
   int            rc, ab_at = -1, rs_at = -1;
   bit            aborted, hold_start;

   // Monitor records (cycle numbers relative to the start edge = cycle 0)
   bit            mon_en = 0;
   int            t_start, fr_at, fw_at, rdy_at, err_at, pulses;
   logic [NS-1:0] ss_or;
   logic [RW-1:0] rnd_at_rdy;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, want, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".stage_start"}, 32'(stage_start), 32'(exp_ss));
      chk({tag, ".ld_fr"}, 32'(ld_fr), 32'(exp_fr));
      chk({tag, ".ld_fw"}, 32'(ld_fw), 32'(exp_fw));
      chk({tag, ".ready"}, 32'(ready), 32'(exp_rdy));
      chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
      chk({tag, ".error"}, 32'(error), 32'(exp_err));
      chk({tag, ".round_idx"}, 32'(round_idx), 32'(exp_rnd));
   endtask

   always @(negedge clk) if (check_en) check_outputs("cyc");

   always @(negedge clk) begin
      if (mon_en) begin
         if (ld_fr === 1'b1 && fr_at < 0) fr_at = cycle - t_start;
         if (ld_fw === 1'b1 && fw_at < 0) fw_at = cycle - t_start;
         if (error === 1'b1 && err_at < 0) err_at = cycle - t_start;
         if (ready === 1'b1 && rdy_at < 0) begin
            rdy_at = cycle - t_start;
            rnd_at_rdy = round_idx;
         end
         if (stage_start != '0) begin
            pulses++;
            ss_or = ss_or | stage_start;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_exp();
      exp_ss = '0; exp_fr = 0; exp_fw = 0; exp_rdy = 0; exp_busy = 0;
      exp_rnd = m_rnd; exp_err = m_err;
   endtask

   // One IDLE cycle; st=1 issues a start with the given configuration.
   task automatic idle_cyc(input bit st, input logic [NS-1:0] m, input logic [RW-1:0] r);
      set_idle_exp();
      start = st;
      abort = 1'($urandom);
      stage_ready = NS'($urandom);
      stage_mask = st ? m : NS'($urandom);
      rounds_cfg = st ? r : RW'($urandom);
      if (st) begin
         t_start = cycle; fr_at = -1; fw_at = -1; rdy_at = -1; err_at = -1;
         pulses = 0; ss_or = '0; rnd_at_rdy = '0; mon_en = 1;
      end
      tick();
   endtask

   // One busy cycle with the given expected strobes; applies planned abort / reset.
   task automatic cyc(input logic [NS-1:0] ss, input bit fr, input bit fw, input bit rdy);
      exp_ss = ss; exp_fr = fr; exp_fw = fw; exp_rdy = rdy; exp_busy = 1;
      exp_rnd = m_rnd; exp_err = 0;
      start = hold_start ? 1'b1 : 1'($urandom);
      stage_mask = NS'($urandom);
      rounds_cfg = RW'($urandom);
      abort = (rc == ab_at);
      if (rc == rs_at) begin
         #2 rst = 1'b1;
         #1;
         m_rnd = '0; m_err = 0;
         set_idle_exp();
         check_outputs("rst_async");
         aborted = 1;
      end
      tick();
      if (rst) rst = 1'b0;
      if (abort) aborted = 1;
      abort = 1'b0;
      rc++;
   endtask

   // Whole-run model: LOAD, then per round each enabled stage (pulse + wait), WRITE, DONE.
   // dly<0 picks a random ready delay per stage; hang is a stage that never answers.
   task automatic run(input logic [NS-1:0] m, input logic [RW-1:0] r, input int dly,
                      input int hang, input int ab, input int rs, input bit hs);
      int d, w;
      bit got;
      logic [NS-1:0] onehot;
      ab_at = ab; rs_at = rs; hold_start = hs; rc = 0; aborted = 0;
      idle_cyc(1, m, r);
      m_rnd = '0; m_err = 0;
      stage_ready = NS'($urandom);
      cyc('0, 1, 0, 0);
      if (aborted) return;
      if (m != '0 && r != '0) begin
         for (int rr = 0; rr < int'(r); rr++) begin
            for (int k = 0; k < NS; k++) begin
               if (m[k]) begin
                  m_rnd = RW'(rr);
                  onehot = '0;
                  onehot[k] = 1'b1;
                  stage_ready = NS'($urandom);
                  cyc(onehot, 0, 0, 0);
                  if (aborted) return;
                  d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
                  w = 0;
                  got = 0;
                  while (!got) begin
                     stage_ready = NS'($urandom);
                     stage_ready[k] = (k != hang) && (w == d);
                     cyc('0, 0, 0, 0);
                     w++;
                     if (aborted) return;
                     if (k != hang && w == d + 1) got = 1;
                     else if (w == 1023) begin
                        m_err = 1;
                        return;
                     end
                  end
               end
            end
         end
      end
      stage_ready = NS'($urandom);
      cyc('0, 0, 1, 0);
      if (aborted) return;
      cyc('0, 0, 0, 1);
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) idle_cyc(0, '0, '0);
   endtask

   initial begin
      logic [NS-1:0] m;
      logic [RW-1:0] r;
      int ab, rs;
      hold_start = 0;
      set_idle_exp();
      #1 rst = 1'b1;
      check_en = 1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idles(2);

      // Full mask, two rounds
      run(5'b11111, 5'd2, 0, -1, -1, -1, 0);
      idles(2);
      chk("s35.ld_fr_cycle", 32'(fr_at), 32'd1);
      chk("s35.ld_fw_cycle", 32'(fw_at), 32'd22);
      chk("s35.ready_cycle", 32'(rdy_at), 32'd23);
      chk("s35.pulses", 32'(pulses), 32'd10);
      chk("s35.final_round", 32'(rnd_at_rdy), 32'd1);

      // Sparse mask, one round
      run(5'b10100, 5'd1, 0, -1, -1, -1, 0);
      idles(1);
      chk("s36.ready_cycle", 32'(rdy_at), 32'd7);
      chk("s36.ld_fw_cycle", 32'(fw_at), 32'd6);
      chk("s36.pulses", 32'(pulses), 32'd2);
      chk("s36.stages", 32'(ss_or), 32'b10100);

      // Empty mask / zero rounds
      run(5'b00000, 5'd3, 0, -1, -1, -1, 0);
      idles(1);
      chk("s37a.ld_fr_cycle", 32'(fr_at), 32'd1);
      chk("s37a.ld_fw_cycle", 32'(fw_at), 32'd2);
      chk("s37a.ready_cycle", 32'(rdy_at), 32'd3);
      chk("s37a.pulses", 32'(pulses), 32'd0);
      run(5'b01101, 5'd0, 0, -1, -1, -1, 0);
      idles(1);
      chk("s37b.ready_cycle", 32'(rdy_at), 32'd3);
      chk("s37b.pulses", 32'(pulses), 32'd0);

      // Stage 3 never answers: timeout
      run(5'b11111, 5'd1, 0, 3, -1, -1, 0);
      idles(2);
      chk("s38.error_cycle", 32'(err_at), 32'd1032);
      chk("s38.no_ready", 32'(rdy_at), 32'hffffffff);
      chk("s38.no_ld_fw", 32'(fw_at), 32'hffffffff);
      chk("s38.pulses", 32'(pulses), 32'd4);
      run(5'b00011, 5'd1, 0, -1, -1, -1, 0);
      chk("s38.error_cleared", 32'(error), 32'd0);
      idles(1);

      // Abort in WAIT of stage 2 together with its ready
      run(5'b11111, 5'd2, 0, -1, 6, -1, 0);
      idles(2);
      chk("s39.pulses", 32'(pulses), 32'd3);
      chk("s39.stages", 32'(ss_or), 32'b00111);
      chk("s39.no_ld_fw", 32'(fw_at), 32'hffffffff);
      chk("s39.no_ready", 32'(rdy_at), 32'hffffffff);

      // Reset mid-run with start held high, then start on the first edge after release
      run(5'b11111, 5'd3, 0, -1, -1, 13, 1);
      chk("s40.no_ready", 32'(rdy_at), 32'hffffffff);
      run(5'b00110, 5'd2, 0, -1, -1, -1, 0);
      idles(1);
      chk("s40.ld_fr_cycle", 32'(fr_at), 32'd1);
      chk("s40.ready_cycle", 32'(rdy_at), 32'd11);
      chk("s40.final_round", 32'(rnd_at_rdy), 32'd1);

      // Randomized runs
      for (int i = 0; i < 40; i++) begin
         m = ($urandom_range(0, 7) == 0) ? '0 : NS'($urandom);
         r = RW'($urandom_range(0, 3));
         ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 25)) : -1;
         rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 25)) : -1;
         run(m, r, -1, -1, ab, rs, 1'($urandom_range(0, 1)));
         idles(int'($urandom_range(0, 2)));
      end
      idles(2);

      check_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
